// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: double-buffered display data applied at
// frame boundaries, blanking guard at the start of each slot, live enables/zero blanking.
module seg_scan_ctrl #(
   parameter int unsigned TICK_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        wr_en,
   input  logic [15:0] wr_data,
   input  logic [3:0]  wr_dp,
   output logic        wr_ready,
   input  logic [3:0]  dig_en,
   input  logic        lz_sup,
   output logic [3:0]  num,
   output logic [3:0]  an_n,
   output logic        dp_n,
   output logic        frame_done
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);

   typedef enum logic {
      PH_BLANK,
      PH_SHOW
   } phase_t;

   logic [CW-1:0] div_cnt;
   logic [1:0]    dig_idx;
   logic [15:0]   active_data;
   logic [3:0]    active_dp;
   logic [15:0]   pending_data;
   logic [3:0]    pending_dp;
   logic          pending_valid;

   phase_t        phase;
   logic          slot_end;
   logic          frame_end;
   logic [3:0]    sup;
   logic [3:0]    onehot;
   logic [3:0]    cur_nib;
   logic          lit;

   always_comb begin
      phase     = (div_cnt < BLANK_END) ? PH_BLANK : PH_SHOW;
      slot_end  = (div_cnt == LAST_CNT);
      frame_end = slot_end && (dig_idx == 2'd3);
      wr_ready  = ~pending_valid;
   end

   // A digit is blanked only if it and every more-significant digit are zero.
   always_comb begin
      sup    = '0;
      sup[3] = lz_sup & (active_data[15:12] == 4'h0);
      sup[2] = lz_sup & (active_data[15:8]  == 8'h00);
      sup[1] = lz_sup & (active_data[15:4]  == 12'h000);
   end

   always_comb begin
      onehot  = 4'b0001 << dig_idx;
      cur_nib = active_data[{dig_idx, 2'b00} +: 4];
      lit     = (phase == PH_SHOW) && dig_en[dig_idx] && !sup[dig_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt       <= '0;
         dig_idx       <= '0;
         active_data   <= '0;
         active_dp     <= '0;
         pending_data  <= '0;
         pending_dp    <= '0;
         pending_valid <= 1'b0;
         frame_done    <= 1'b0;
         an_n          <= '1;
         num           <= '0;
         dp_n          <= 1'b1;
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
         if (slot_end) begin
            dig_idx <= dig_idx + 1'b1;
         end
         frame_done <= frame_end;

         // Pending is only ever full when wr_ready is low, so the swap and an
         // accepted write can never coincide.
         if (frame_end && pending_valid) begin
            active_data   <= pending_data;
            active_dp     <= pending_dp;
            pending_valid <= 1'b0;
         end else if (wr_en && !pending_valid) begin
            pending_data  <= wr_data;
            pending_dp    <= wr_dp;
            pending_valid <= 1'b1;
         end

         an_n <= lit ? ~onehot : '1;
         num  <= cur_nib;
         dp_n <= ~(lit & active_dp[dig_idx]);
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: reset values, table of display vectors swept
// over a whole frame, and hand sequences for write back-pressure and resets.
module tb_seg_scan_ctrl;

   localparam int unsigned TD = 16;
   localparam int unsigned BC = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        wr_en = 1'b0;
   logic [15:0] wr_data = '0;
   logic [3:0]  wr_dp = '0;
   logic        wr_ready;
   logic [3:0]  dig_en = 4'hF;
   logic        lz_sup = 1'b0;
   logic [3:0]  num;
   logic [3:0]  an_n;
   logic        dp_n;
   logic        frame_done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] data;
      logic [3:0]  dp;
      logic [3:0]  en;
      logic        lz;
      logic [15:0] x_num;  // nibble i = expected num in slot i
      logic [15:0] x_an;   // nibble i = expected an_n in slot i (SHOW phase)
      logic [3:0]  x_dpn;  // bit i = expected dp_n in slot i (SHOW phase)
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .TICK_DIV (TD),
      .BLANK_CYC(BC)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_dp     (wr_dp),
      .wr_ready  (wr_ready),
      .dig_en    (dig_en),
      .lz_sup    (lz_sup),
      .num       (num),
      .an_n      (an_n),
      .dp_n      (dp_n),
      .frame_done(frame_done)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an_n"}, an_n, 4'hF);
      check({tag, "_num"}, num, 4'h0);
      check({tag, "_dp_n"}, dp_n, 1'b1);
      check({tag, "_wr_ready"}, wr_ready, 1'b1);
      check({tag, "_frame_done"}, frame_done, 1'b0);
   endtask

   task automatic write_word(input logic [15:0] data, input logic [3:0] dp);
      int n = 0;
      while (wr_ready !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      check("wr_ready_before_write", wr_ready, 1'b1);
      wr_en   = 1'b1;
      wr_data = data;
      wr_dp   = dp;
      step();
      wr_en = 1'b0;
      check("wr_ready_after_write", wr_ready, 1'b0);
   endtask

   task automatic wait_frame();
      int n = 0;
      do begin
         step();
         n++;
      end while (frame_done !== 1'b1 && n < 300);
      check("frame_done_seen", frame_done, 1'b1);
   endtask

   // Called right after a frame_done sample; walks the following frame.
   task automatic sweep(input string tag, input logic [15:0] xn, input logic [15:0] xa,
                        input logic [3:0] xd);
      for (int j = 1; j <= 64; j++) begin
         int slot;
         int pos;
         logic [15:0] nsh;
         logic [15:0] ash;
         step();
         slot = (j - 1) / 16;
         pos  = (j - 1) % 16;
         check($sformatf("%s_frame_done_j%0d", tag, j), frame_done, (j == 64));
         if (pos == 1 || pos == 2 || pos == 15) begin
            nsh = xn >> (slot * 4);
            ash = xa >> (slot * 4);
            check($sformatf("%s_s%0d_p%0d_num", tag, slot, pos), num, nsh[3:0]);
            if (pos == 1) begin
               check($sformatf("%s_s%0d_p%0d_an_n", tag, slot, pos), an_n, 4'hF);
               check($sformatf("%s_s%0d_p%0d_dp_n", tag, slot, pos), dp_n, 1'b1);
            end else begin
               check($sformatf("%s_s%0d_p%0d_an_n", tag, slot, pos), an_n, ash[3:0]);
               check($sformatf("%s_s%0d_p%0d_dp_n", tag, slot, pos), dp_n, xd[slot]);
            end
         end
      end
   endtask

   // Expects dig_en=F, lz_sup=0; active data must have been cleared by reset.
   task automatic after_reset_check(input string tag);
      int seen = 0;
      for (int j = 1; j <= 200; j++) begin
         step();
         if (j == 3) begin
            check({tag, "_slot0_num"}, num, 4'h0);
            check({tag, "_slot0_an_n"}, an_n, 4'hE);
            check({tag, "_slot0_dp_n"}, dp_n, 1'b1);
            check({tag, "_wr_ready"}, wr_ready, 1'b1);
         end
         if (frame_done === 1'b1) begin
            seen = j;
            break;
         end
      end
      check({tag, "_first_frame_cycle"}, 16'(seen), 16'd64);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{16'h1234, 4'b0001, 4'hF, 1'b0, 16'h1234, 16'h7BDE, 4'b1110};
      vecs[1] = '{16'h0050, 4'b0000, 4'hF, 1'b1, 16'h0050, 16'hFFDE, 4'b1111};
      vecs[2] = '{16'h0000, 4'b0000, 4'hF, 1'b1, 16'h0000, 16'hFFFE, 4'b1111};
      vecs[3] = '{16'h0000, 4'b0000, 4'hF, 1'b0, 16'h0000, 16'h7BDE, 4'b1111};
      vecs[4] = '{16'h9876, 4'b0000, 4'h5, 1'b0, 16'h9876, 16'hFBFE, 4'b1111};
      vecs[5] = '{16'h9876, 4'b1111, 4'h5, 1'b0, 16'h9876, 16'hFBFE, 4'b1010};
      vecs[6] = '{16'h0500, 4'b1110, 4'hF, 1'b1, 16'h0500, 16'hFBDE, 4'b1001};

      // Asynchronous reset before any clock edge.
      #1 rst_n = 1'b0;
      #2 check_reset_outputs("por");
      step();
      check_reset_outputs("por_held");
      rst_n = 1'b1;
      after_reset_check("por");

      foreach (vecs[i]) begin
         dig_en = vecs[i].en;
         lz_sup = vecs[i].lz;
         write_word(vecs[i].data, vecs[i].dp);
         wait_frame();
         sweep($sformatf("vec%0d", i), vecs[i].x_num, vecs[i].x_an, vecs[i].x_dpn);
      end

      // Second write while pending is full must be dropped.
      dig_en = 4'hF;
      lz_sup = 1'b0;
      write_word(16'hAAAA, 4'b0000);
      wr_en   = 1'b1;
      wr_data = 16'h5555;
      wr_dp   = 4'b1111;
      step();
      wr_en = 1'b0;
      check("ignored_write_wr_ready", wr_ready, 1'b0);
      wait_frame();
      sweep("aaaa_f1", 16'hAAAA, 16'h7BDE, 4'hF);
      check("aaaa_wr_ready_free", wr_ready, 1'b1);
      sweep("aaaa_f2", 16'hAAAA, 16'h7BDE, 4'hF);

      // Mid-slot dig_en toggle, slot 0 SHOW phase.
      repeat (6) step();
      check("toggle_before_an_n", an_n, 4'hE);
      dig_en = 4'hE;
      step();
      check("toggle_off_an_n", an_n, 4'hF);
      check("toggle_off_num", num, 4'hA);
      dig_en = 4'hF;
      step();
      check("toggle_on_an_n", an_n, 4'hE);

      // Reset while active=AAAA and pending holds an unapplied write.
      write_word(16'h1111, 4'b1111);
      rst_n = 1'b0;
      #2 check_reset_outputs("midrun");
      step();
      check_reset_outputs("midrun_held");
      rst_n = 1'b1;
      after_reset_check("midrun");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit seven-segment display. It drives the shared hex-to-segment decoder: one nibble per digit slot, with anode selects and a decimal point. Display values arrive through a ready/valid-style write port. They are double-buffered and applied only at frame boundaries, so no digit tears mid-frame. Sits between the game score/timer logic and the segment decoder / board pins.

Parameters:
TICK_DIV, 50000, clock cycles per digit slot (refresh = clk / (4*TICK_DIV)); must be > BLANK_CYC+1
BLANK_CYC, 8, cycles at start of each slot with all anodes off (ghosting guard); must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request; accepted when wr_en & wr_ready
wr_data  in  16  four BCD/hex nibbles; [3:0]=digit0 (rightmost) .. [15:12]=digit3
wr_dp  in  4  decimal-point enables, bit i = digit i, written with wr_data
wr_ready  out  1  pending buffer free
dig_en  in  4  live per-digit enable; 0 = digit dark
lz_sup  in  1  live leading-zero suppression enable
num  out  4  nibble to segment decoder
an_n  out  4  anode selects, active low, bit i = digit i
dp_n  out  1  decimal point, active low
frame_done  out  1  one-cycle pulse when a frame boundary has just occurred

Behaviour:
- Reset (async assert, sync release): div_cnt=0, dig_idx=0, active data/dp=0, pending_valid=0. Outputs: an_n=4'b1111, num=0, dp_n=1, frame_done=0, wr_ready=1.
- div_cnt counts 0..TICK_DIV-1 and then wraps. dig_idx increments on the wrap: 0,1,2,3,0...
- Slot phases: div_cnt < BLANK_CYC = BLANK phase; otherwise SHOW phase.
- Boundary event E: div_cnt==TICK_DIV-1 and dig_idx==3.
- Write handshake:
  - wr_ready = ~pending_valid.
  - On wr_en & wr_ready: pending_data/dp <= wr_data/wr_dp, pending_valid <= 1.
  - wr_en while wr_ready=0 is ignored. No data is lost from pending, and no error is flagged.
- At edge with E:
  - If pending_valid, active <= pending and pending_valid <= 0. wr_ready rises the next cycle.
  - frame_done <= 1 for exactly one cycle.
  - An E with no pending data still pulses frame_done and leaves active unchanged.
- Leading-zero suppression: digit i (i=3,2,1) is suppressed when lz_sup=1 and active nibbles i..3 are all zero. Digit 0 is never suppressed.
- Digit i is lit when SHOW phase, dig_idx==i, dig_en[i]=1 and not suppressed.
- Registered outputs, one cycle latency from counter state:
  - an_n = lit ? ~(1<<dig_idx) : 4'b1111.
  - num = active nibble[dig_idx] in every phase, for decoder settling.
  - dp_n = ~(lit & active_dp[dig_idx]).
- dig_en and lz_sup changes take effect within one cycle, even mid-frame. They are not buffered.
- Reset mid-operation: pending and active data are discarded, and the scan restarts at digit 0 in BLANK.
- Counter widths: div_cnt = $clog2(TICK_DIV) bits; dig_idx = 2 bits, with natural wrap.

Test Plan:
- Reset (TICK_DIV=16, BLANK_CYC=2): hold rst_n=0 -> an_n=1111, num=0, dp_n=1, wr_ready=1, frame_done=0. Assert rst_n mid-run -> same values immediately, asynchronously.
- Write 16'h1234, wr_dp=4'b0001, dig_en=1111 -> wr_ready=0 until the first E. frame_done pulses once. Next frame, SHOW cycles give: slot0 num=4, an_n=1110, dp_n=0; slot1 num=3, an_n=1101; slot2 num=2, an_n=1011; slot3 num=1, an_n=0111, dp_n=1. The first 2 cycles (+1 latency) of each slot show an_n=1111.
- Write 16'hAAAA, then write 16'h5555 while wr_ready=0 -> second write ignored. After E, all digits show num=A. A third write is accepted once wr_ready=1.
- lz_sup=1, data 16'h0050 -> slots 3,2 have an_n=1111; slot1 num=5; slot0 num=0 lit. Data 16'h0000 -> only digit0 lit. lz_sup=0 -> all four lit.
- dig_en=4'b0101 with data 16'h9876 -> slots 1 and 3 show an_n=1111 and dp_n=1; slots 0 (num=6) and 2 (num=8) are lit. Toggling dig_en mid-slot changes an_n after one cycle.
- Reset asserted with pending_valid=1 and active=16'h1234 -> after release, active=0 (slot0 num=0) and wr_ready=1. The first frame_done occurs 4*16 cycles after release.
